// File: rtl/matmul_ctrl.sv
// matmul_ctrl: sequencer and MAC engine for C = A x B (A is n x m, B is m x q).
// Operands come from two synchronous-read RAMs, one element pair per cycle.
// Results leave one C element at a time, row-major, over a valid/ready port.
//
// Handshake: a C element transfers on a rising edge where o_c_valid && i_c_ready.
// Once o_c_valid rises, o_c_row/o_c_col/o_c_data stay stable until that transfer.
// o_c_valid never depends on i_c_ready.
module matmul_ctrl #(
  parameter int DATA_WIDTH = 16,
  parameter int MAX_DIM    = 256,
  parameter int IDX_W      = $clog2(MAX_DIM),
  parameter int DIM_W      = IDX_W + 1,
  parameter int ACC_W      = 2 * DATA_WIDTH + IDX_W
) (
  input  logic                         i_clk,
  input  logic                         i_reset,
  input  logic                         i_start,
  input  logic [DIM_W-1:0]             i_n,
  input  logic [DIM_W-1:0]             i_m,
  input  logic [DIM_W-1:0]             i_m2,
  input  logic [DIM_W-1:0]             i_q,
  output logic                         o_busy,
  output logic                         o_done,
  output logic                         o_err,
  output logic                         o_a_rd_en,
  output logic [IDX_W-1:0]             o_a_row,
  output logic [IDX_W-1:0]             o_a_col,
  output logic                         o_b_rd_en,
  output logic [IDX_W-1:0]             o_b_row,
  output logic [IDX_W-1:0]             o_b_col,
  input  logic signed [DATA_WIDTH-1:0] i_a_data,
  input  logic signed [DATA_WIDTH-1:0] i_b_data,
  output logic                         o_c_valid,
  output logic [IDX_W-1:0]             o_c_row,
  output logic [IDX_W-1:0]             o_c_col,
  output logic [DATA_WIDTH-1:0]        o_c_data,
  input  logic                         i_c_ready,
  output logic [2:0]                   o_state
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_CHECK = 3'd1,
    S_FETCH = 3'd2,
    S_DRAIN = 3'd3,
    S_WRITE = 3'd4,
    S_DONE  = 3'd5,
    S_ERR   = 3'd6
  } state_t;

  state_t                         r_state;
  state_t                         w_state_nxt;
  logic [DIM_W-1:0]               r_n, r_m, r_m2, r_q;
  logic [IDX_W-1:0]               r_i, r_j, r_k;
  logic signed [ACC_W-1:0]        r_acc;
  logic                           r_rd_valid;

  logic                           w_rd_en;
  logic                           w_c_valid;
  logic                           w_done;
  logic                           w_err;
  logic                           w_cmd_bad;
  logic                           w_i_last, w_j_last, w_k_last;
  logic                           w_accept;
  logic signed [2*DATA_WIDTH-1:0] w_prod;
  logic signed [ACC_W-1:0]        w_prod_ext;

  // Command validity and loop-end conditions on the latched dimensions
  assign w_cmd_bad = (r_n == '0) || (r_m == '0) || (r_q == '0) ||
                     (r_n > DIM_W'(MAX_DIM)) || (r_m > DIM_W'(MAX_DIM)) ||
                     (r_q > DIM_W'(MAX_DIM)) || (r_m != r_m2);
  assign w_i_last  = ({1'b0, r_i} == r_n - DIM_W'(1));
  assign w_j_last  = ({1'b0, r_j} == r_q - DIM_W'(1));
  assign w_k_last  = ({1'b0, r_k} == r_m - DIM_W'(1));
  assign w_accept  = w_c_valid && i_c_ready;

  // Full-width signed product, sign-extended to the accumulator width
  assign w_prod     = i_a_data * i_b_data;
  assign w_prod_ext = {{(ACC_W - 2*DATA_WIDTH){w_prod[2*DATA_WIDTH-1]}}, w_prod};

  // Next-state and per-state control strobes
  always_comb begin
    w_state_nxt = r_state;
    w_rd_en     = 1'b0;
    w_c_valid   = 1'b0;
    w_done      = 1'b0;
    w_err       = 1'b0;
    case (r_state)
      S_IDLE:  if (i_start) w_state_nxt = S_CHECK;
      S_CHECK: w_state_nxt = w_cmd_bad ? S_ERR : S_FETCH;
      S_FETCH: begin
        w_rd_en = 1'b1;
        if (w_k_last) w_state_nxt = S_DRAIN;
      end
      S_DRAIN: w_state_nxt = S_WRITE;
      S_WRITE: begin
        w_c_valid = 1'b1;
        if (i_c_ready) w_state_nxt = (w_i_last && w_j_last) ? S_DONE : S_FETCH;
      end
      S_DONE: begin
        w_done      = 1'b1;
        w_state_nxt = S_IDLE;
      end
      S_ERR: begin
        w_done      = 1'b1;
        w_err       = 1'b1;
        w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // State register
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) r_state <= S_IDLE;
    else         r_state <= w_state_nxt;
  end

  // Dimension latch, loop indices, read-valid pipe and accumulator
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_n        <= '0;
      r_m        <= '0;
      r_m2       <= '0;
      r_q        <= '0;
      r_i        <= '0;
      r_j        <= '0;
      r_k        <= '0;
      r_acc      <= '0;
      r_rd_valid <= 1'b0;
    end else begin
      r_rd_valid <= w_rd_en;
      if (r_state == S_IDLE && i_start) begin
        r_n  <= i_n;
        r_m  <= i_m;
        r_m2 <= i_m2;
        r_q  <= i_q;
      end
      if (r_state == S_CHECK) begin
        r_i <= '0;
        r_j <= '0;
        r_k <= '0;
      end
      if (r_state == S_FETCH) r_k <= w_k_last ? '0 : r_k + IDX_W'(1);
      if (w_accept) begin
        if (w_j_last) begin
          r_j <= '0;
          r_i <= r_i + IDX_W'(1);
        end else begin
          r_j <= r_j + IDX_W'(1);
        end
      end
      if (r_state == S_CHECK || w_accept) r_acc <= '0;
      else if (r_rd_valid)                r_acc <= r_acc + w_prod_ext;
    end
  end

  // Outputs are zero whenever their strobe is low, so reset clears them at once
  assign o_busy    = (r_state != S_IDLE);
  assign o_done    = w_done;
  assign o_err     = w_err;
  assign o_a_rd_en = w_rd_en;
  assign o_b_rd_en = w_rd_en;
  assign o_a_row   = w_rd_en ? r_i : '0;
  assign o_a_col   = w_rd_en ? r_k : '0;
  assign o_b_row   = w_rd_en ? r_k : '0;
  assign o_b_col   = w_rd_en ? r_j : '0;
  assign o_c_valid = w_c_valid;
  assign o_c_row   = w_c_valid ? r_i : '0;
  assign o_c_col   = w_c_valid ? r_j : '0;
  assign o_c_data  = w_c_valid ? r_acc[DATA_WIDTH-1:0] : '0;
  assign o_state   = r_state;

endmodule

// File: tb/tb_matmul_ctrl.sv
// tb_matmul_ctrl: drives matrix commands into matmul_ctrl, serves the A/B RAMs,
// and checks every read request and C write against a matrix-level model.
module tb_matmul_ctrl;

  localparam int DW = 16;
  localparam int IW = 8;
  localparam int NW = 9;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- DUT ----------------
  logic                 start = 1'b0;
  logic [NW-1:0]        n = '0, m = '0, m2 = '0, q = '0;
  logic                 busy, done, err;
  logic                 a_rd_en, b_rd_en;
  logic [IW-1:0]        a_row, a_col, b_row, b_col;
  logic signed [DW-1:0] a_data = '0, b_data = '0;
  logic                 c_valid;
  logic [IW-1:0]        c_row, c_col;
  logic [DW-1:0]        c_data;
  logic                 c_ready = 1'b0;
  logic [2:0]           state;

  matmul_ctrl dut (
    .i_clk(clk), .i_reset(reset), .i_start(start),
    .i_n(n), .i_m(m), .i_m2(m2), .i_q(q),
    .o_busy(busy), .o_done(done), .o_err(err),
    .o_a_rd_en(a_rd_en), .o_a_row(a_row), .o_a_col(a_col),
    .o_b_rd_en(b_rd_en), .o_b_row(b_row), .o_b_col(b_col),
    .i_a_data(a_data), .i_b_data(b_data),
    .o_c_valid(c_valid), .o_c_row(c_row), .o_c_col(c_col), .o_c_data(c_data),
    .i_c_ready(c_ready), .o_state(state)
  );

  // ---------------- bench state ----------------
  logic signed [DW-1:0] a_mem [0:255][0:255];
  logic signed [DW-1:0] b_mem [0:255][0:255];
  logic [31:0] exp_q[$];     // {row, col, data} of each expected C write
  logic [31:0] exp_rd_q[$];  // {a_row, a_col, b_row, b_col} of each expected read
  int  checks = 0;
  int  errors = 0;
  int  stalls = 0;
  int  rmode = 0;            // 0: ready high, 1: random, 2: low for first 3 WRITE cycles
  bit  chk_reads = 1'b1;
  bit  noise_en = 1'b0;

  task automatic check(input string name, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Matrix-level reference: C[i][j] = sum_k A[i][k]*B[k][j], truncated to DW bits
  function automatic logic [DW-1:0] model_c(input int i, input int j, input int mm);
    longint s = 0;
    for (int k = 0; k < mm; k++) s += longint'(a_mem[i][k]) * longint'(b_mem[k][j]);
    return s[DW-1:0];
  endfunction

  // ---------------- RAM model (one-cycle read latency) ----------------
  initial begin
    logic en;
    logic [IW-1:0] ar, ac, br, bc;
    forever begin
      @(negedge clk);
      en = a_rd_en; ar = a_row; ac = a_col; br = b_row; bc = b_col;
      @(posedge clk);
      #1;
      if (en) begin
        a_data = a_mem[ar][ac];
        b_data = b_mem[br][bc];
      end else begin
        a_data = DW'($urandom);  // garbage must never reach the accumulator
        b_data = DW'($urandom);
      end
    end
  end

  // ---------------- ready / start-noise driver ----------------
  initial begin
    forever begin
      @(posedge clk);
      #1;
      case (rmode)
        0:       c_ready = 1'b1;
        1:       c_ready = ($urandom_range(0, 3) != 0);
        default: c_ready = (stalls >= 3);
      endcase
      if (noise_en) begin
        start = busy ? 1'($urandom_range(0, 1)) : 1'b0;
        if (busy) begin
          n  = NW'($urandom_range(0, 3));
          m  = NW'($urandom_range(0, 3));
          m2 = NW'($urandom_range(0, 3));
          q  = NW'($urandom_range(0, 3));
        end
      end
    end
  end

  // ---------------- compare process ----------------
  initial begin
    logic        prev_stall = 1'b0;
    logic [31:0] prev_c = '0;
    logic [31:0] e;
    forever begin
      @(negedge clk);
      if (reset) begin
        prev_stall = 1'b0;
      end else begin
        check("rd_wr_exclusive", a_rd_en & c_valid, 0);
        check("rd_en_pair", b_rd_en, a_rd_en);
        if (a_rd_en && chk_reads) begin
          if (exp_rd_q.size() == 0) check("unexpected_read", 1, 0);
          else begin
            e = exp_rd_q.pop_front();
            check("read_addr", {a_row, a_col, b_row, b_col}, e);
          end
        end
        if (prev_stall) check("c_hold", {c_valid, c_row, c_col, c_data}, {1'b1, prev_c});
        if (c_valid) begin
          if (c_ready) begin
            if (exp_q.size() == 0) check("unexpected_write", 1, 0);
            else begin
              e = exp_q.pop_front();
              check("c_write", {c_row, c_col, c_data}, e);
            end
          end else begin
            stalls++;
          end
        end
        prev_stall = c_valid && !c_ready;
        prev_c     = {c_row, c_col, c_data};
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic fill_random(input int nn, input int mm, input int qq);
    for (int i = 0; i < nn; i++)
      for (int k = 0; k < mm; k++) a_mem[i][k] = DW'($urandom);
    for (int k = 0; k < mm; k++)
      for (int j = 0; j < qq; j++) b_mem[k][j] = DW'($urandom);
  endtask

  // Issue one command, push the model's expectations, wait for done and check it.
  task automatic run_cmd(input int tn, input int tm, input int tm2, input int tq,
                         input int mode, input bit noise, output int done_c);
    bit valid;
    int t0, cc, exp_done;
    bit got;
    valid = (tn >= 1 && tn <= 256) && (tm >= 1 && tm <= 256) &&
            (tq >= 1 && tq <= 256) && (tm == tm2);
    exp_q.delete();
    exp_rd_q.delete();
    chk_reads = 1'b1;
    if (valid) begin
      for (int i = 0; i < tn; i++)
        for (int j = 0; j < tq; j++) begin
          for (int k = 0; k < tm; k++) exp_rd_q.push_back({8'(i), 8'(k), 8'(k), 8'(j)});
          exp_q.push_back({8'(i), 8'(j), model_c(i, j, tm)});
        end
    end
    @(posedge clk);
    #1;
    rmode = mode;
    stalls = 0;
    n = NW'(tn); m = NW'(tm); m2 = NW'(tm2); q = NW'(tq);
    start = 1'b1;
    t0 = cyc;
    @(negedge clk);
    check("busy_cycle0", busy, 0);
    @(posedge clk);
    #1;
    start = 1'b0;
    noise_en = noise;
    got = 1'b0;
    done_c = -1;
    for (int w = 0; w < 20000 && !got; w++) begin
      @(negedge clk);
      cc = cyc - t0;
      if (cc == 1) check("busy_cycle1", busy, 1);
      if (done) begin
        got = 1'b1;
        done_c = cc;
        check("err_flag", err, valid ? 0 : 1);
      end
    end
    if (!got) check("done_timeout", 0, 1);
    exp_done = valid ? 2 + tn * tq * (tm + 2) + stalls : 2;
    check("done_cycle", done_c, exp_done);
    check("writes_left", exp_q.size(), 0);
    check("reads_left", exp_rd_q.size(), 0);
    @(posedge clk);
    #1;
    start = 1'b0;
    noise_en = 1'b0;
    @(negedge clk);
    check("busy_after_done", busy, 0);
    check("done_single", done, 0);
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_outs"},
          {busy, done, err, a_rd_en, a_row, a_col, b_rd_en, b_row, b_col,
           c_valid, c_row, c_col, c_data}, 0);
    check({tag, "_state"}, state, 0);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int dc;
    int tn, tm, tq, kind;

    repeat (3) @(posedge clk);
    #2;
    check_outputs_zero("reset");
    @(negedge clk);
    reset = 1'b0;

    // 1x1x1: 3 * -2 = -6, done in cycle 5
    a_mem[0][0] = 16'sd3;
    b_mem[0][0] = -16'sd2;
    check("model_1x1", $signed(model_c(0, 0, 1)), -6);
    run_cmd(1, 1, 1, 1, 0, 0, dc);
    check("lit_done_1x1", dc, 5);

    // 2x2x2 with known operands
    a_mem[0][0] = 1; a_mem[0][1] = 2; a_mem[1][0] = 3; a_mem[1][1] = 4;
    b_mem[0][0] = 5; b_mem[0][1] = 6; b_mem[1][0] = 7; b_mem[1][1] = 8;
    check("model_2x2_00", model_c(0, 0, 2), 19);
    check("model_2x2_01", model_c(0, 1, 2), 22);
    check("model_2x2_10", model_c(1, 0, 2), 43);
    check("model_2x2_11", model_c(1, 1, 2), 50);
    run_cmd(2, 2, 2, 2, 0, 0, dc);
    check("lit_done_2x2", dc, 18);

    // Same case with 3 stall cycles at the first WRITE
    run_cmd(2, 2, 2, 2, 2, 0, dc);
    check("lit_done_2x2_stall", dc, 21);
    check("lit_stalls", stalls, 3);

    // Rejected commands
    run_cmd(2, 3, 4, 2, 0, 0, dc);
    check("lit_done_rej_m2", dc, 2);
    run_cmd(0, 2, 2, 2, 0, 0, dc);
    check("lit_done_rej_n0", dc, 2);

    // Wrap: 2 * 32767^2 = 0x7FFE0002 -> low 16 bits = 2
    a_mem[0][0] = 16'sd32767; a_mem[0][1] = 16'sd32767;
    b_mem[0][0] = 16'sd32767; b_mem[1][0] = 16'sd32767;
    check("model_wrap", model_c(0, 0, 2), 2);
    run_cmd(1, 2, 2, 1, 0, 0, dc);
    check("lit_done_wrap", dc, 6);

    // Randomized valid commands with random backpressure and start noise
    for (int t = 0; t < 25; t++) begin
      tn = $urandom_range(1, 4);
      tm = $urandom_range(1, 5);
      tq = $urandom_range(1, 4);
      fill_random(tn, tm, tq);
      run_cmd(tn, tm, tm, tq, $urandom_range(0, 1), 1'($urandom_range(0, 1)), dc);
    end

    // Randomized rejected commands
    for (int t = 0; t < 8; t++) begin
      kind = $urandom_range(0, 4);
      tn = $urandom_range(1, 3); tm = $urandom_range(1, 3); tq = $urandom_range(1, 3);
      case (kind)
        0: run_cmd(0, tm, tm, tq, 0, 0, dc);
        1: run_cmd(tn, 0, 0, tq, 0, 0, dc);
        2: run_cmd(tn, tm, tm, 0, 0, 0, dc);
        3: run_cmd(tn, tm, tm + 1, tq, 1, 0, dc);
        default: run_cmd(257 + $urandom_range(0, 200), tm, tm, tq, 0, 0, dc);
      endcase
    end

    // Reset in the middle of a 256x256x256 run
    exp_q.delete();
    exp_rd_q.delete();
    chk_reads = 1'b0;
    @(posedge clk);
    #1;
    rmode = 0;
    n = 9'd256; m = 9'd256; m2 = 9'd256; q = 9'd256;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    noise_en = 1'b1;
    repeat (40) @(negedge clk);
    check("big_fetching", a_rd_en, 1);
    check("big_busy", busy, 1);
    #2;
    reset = 1'b1;
    #1;
    check_outputs_zero("mid_reset");
    noise_en = 1'b0;
    start = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check_outputs_zero("held_reset");
    reset = 1'b0;

    // Normal command after reset
    a_mem[0][0] = -16'sd7;
    b_mem[0][0] = 16'sd9;
    check("model_post_reset", $signed(model_c(0, 0, 1)), -63);
    run_cmd(1, 1, 1, 1, 0, 0, dc);
    check("lit_done_post_reset", dc, 5);

    repeat (3) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Global watchdog
  initial begin
    #5000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/matmul_ctrl.md
# matmul_ctrl

Sequencing controller and MAC engine for the signed matrix-multiply datapath. It computes C = A × B with A sized n×m and B sized m×q. Operands are read from two external synchronous-read matrix RAMs, one element per cycle. Results are accumulated internally and emitted one C element at a time over a valid/ready write port in row-major order. It sits between the command source (start + dimensions) and the A/B/C matrix memories.

## Interface
- DATA_WIDTH, 16, signed element width of A, B, C
- MAX_DIM, 256, maximum value of any dimension
- IDX_W, $clog2(MAX_DIM) = 8, row/column index width
- DIM_W, IDX_W+1 = 9, dimension field width (must hold MAX_DIM)
- ACC_W, 2*DATA_WIDTH+IDX_W = 40, signed accumulator width
- clk  in  1  clock, all state updates on rising edge
- reset  in  1  asynchronous, active-high; returns the block to IDLE
- start  in  1  command strobe, sampled only in IDLE
- n, m, m2, q  in  DIM_W each  A rows, A cols, B rows, B cols
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle completion pulse
- err  out  1  one-cycle pulse coincident with done when the command is rejected
- a_rd_en, a_row, a_col  out  1/IDX_W/IDX_W  A read request; a_data is valid the cycle after a_rd_en
- b_rd_en, b_row, b_col  out  1/IDX_W/IDX_W  B read request; b_data is valid the cycle after b_rd_en
- a_data, b_data  in  DATA_WIDTH  signed read data
- c_valid, c_row, c_col, c_data  out  1/IDX_W/IDX_W/DATA_WIDTH  result write
- c_ready  in  1  sink accepts C element when c_valid && c_ready

## Operation
- States: IDLE, CHECK, FETCH, DRAIN, WRITE, DONE, ERR.
- IDLE: on start=1, latch n, m, m2, q and go to CHECK. start is ignored in every other state.
- CHECK: the command is invalid if any of n, m, q is 0, any dimension exceeds MAX_DIM, or m != m2.
  - Invalid: go to ERR.
  - Valid: set i=j=k=0, clear acc, go to FETCH.
- FETCH:
  - Drive a_rd_en = b_rd_en = 1, A address (i,k), B address (k,j).
  - If k == m-1: set k=0 and go to DRAIN. Otherwise k++.
- Accumulate path: rd_valid is a_rd_en delayed by one cycle. When rd_valid=1, acc <= acc + sign-extended (a_data*b_data), using a full 2*DATA_WIDTH signed product.
- DRAIN: no reads are issued. The last product is accumulated at the end of this cycle. Go to WRITE.
- WRITE:
  - Drive c_valid=1, c_row=i, c_col=j, c_data=acc[DATA_WIDTH-1:0]. The result is truncated (wraps); there is no saturation.
  - Hold all four outputs stable until c_ready. Issue no reads while waiting.
  - On accept: clear acc. If j == q-1: set j=0 and i++; otherwise j++.
  - If the accepted element was (n-1, q-1), go to DONE; otherwise go to FETCH.
- DONE: done=1, err=0 for one cycle, then IDLE.
- ERR: done=1, err=1 for one cycle, then IDLE. No reads or writes occur for a rejected command.
- Read enables and c_valid are never high in the same cycle.

## Timing
- Reset values: every output is 0. Internal acc, i, j, k, and rd_valid are 0. The state is IDLE.
- Reset during any state takes effect immediately. Any in-flight element is discarded with no partial write.
- Let cycle 0 be the cycle start is sampled high in IDLE. CHECK occurs in cycle 1 and the first FETCH in cycle 2.
- Each element takes m FETCH cycles + 1 DRAIN cycle + W WRITE cycles, where W ≥ 1 is the number of cycles until c_ready.
- With c_ready tied high, done is asserted in cycle 2 + n·q·(m+2).
- For a rejected command, done/err are asserted in cycle 2.
- busy rises in cycle 1 and falls the cycle after the done pulse.
- Worst-case accumulator magnitude is MAX_DIM·2^(2·DATA_WIDTH-2), which fits in ACC_W. The accumulator itself never overflows.

## Test plan
- 1×1×1, A=3, B=-2, c_ready=1 -> one write (0,0)=-6; done in cycle 5; err=0.
- 2×2×2, A=[[1,2],[3,4]], B=[[5,6],[7,8]], c_ready=1 -> writes in order (0,0)=19, (0,1)=22, (1,0)=43, (1,1)=50; done in cycle 18.
- Rejects: n=2, m=3, m2=4, q=2, and separately n=0 -> done=err=1 in cycle 2; no rd_en and no c_valid ever asserted.
- Backpressure: the 2×2×2 case with c_ready low for 3 cycles at the first WRITE -> c_valid, c_row, c_col, c_data held stable; no rd_en while stalled; results unchanged; done in cycle 21.
- Wrap: 1×2×1, A=[32767,32767], B=[32767,32767] -> acc=0x7FFE0002, c_data=2.
- Reset mid-FETCH of a 256×256×256 run -> all outputs 0 immediately, busy=0. Start pulses while busy are ignored. A following 1×1×1 command completes normally in cycle 5.
